// File: rtl/i2c_rx_capture.sv
// I2C receive byte capture: samples SDA on rising SCL inside the controller's read
// window, assembles bytes MSB-first and queues them in a first-word-fall-through FIFO.
module i2c_rx_capture #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              i2c_core_clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  input  logic              fifo_rx_enable,
  input  logic              rd_en,
  input  logic              clr_flags,
  output logic [7:0]        rd_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              byte_valid,
  output logic              overflow,
  output logic              frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  state_t              state_q, state_d;
  logic                scl_q;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic                byte_valid_q, byte_valid_d;
  logic                overflow_q, overflow_d;
  logic                frame_err_q, frame_err_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;

  logic                rise;
  logic                push;
  logic                pop;
  logic                wr_en;
  logic                ovf_set;
  logic                frame_set;

  logic [7:0]          mem [FIFO_DEPTH];

  assign rise = scl_in & ~scl_q;

  // Capture state machine: next-state and shift-register logic.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_valid_d = 1'b0;
    frame_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_rx_enable) begin
          state_d   = SHIFT;
          bit_cnt_d = 3'd0;
          if (rise) begin
            shift_d   = {shift_q[6:0], sda_in};
            bit_cnt_d = 3'd1;
          end
        end
      end
      SHIFT: begin
        if (!fifo_rx_enable) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          frame_set = (bit_cnt_q != 3'd0);
        end else if (rise) begin
          shift_d = {shift_q[6:0], sda_in};
          if (bit_cnt_q == 3'd7) begin
            state_d      = PUSH;
            bit_cnt_d    = 3'd0;
            byte_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PUSH: begin
        bit_cnt_d = 3'd0;
        if (fifo_rx_enable) begin
          state_d = SHIFT;
          // SCL may already be rising for the first bit of the next byte.
          if (rise) begin
            shift_d   = {shift_q[6:0], sda_in};
            bit_cnt_d = 3'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // FIFO bookkeeping: a full FIFO still accepts a byte when a pop frees a slot.
  always_comb begin
    push     = (state_q == PUSH);
    pop      = rd_en & ~empty_q;
    wr_en    = push & (~full_q | pop);
    ovf_set  = push & full_q & ~pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (wr_en && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !wr_en) begin
      count_d = count_q - CNT_ONE;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);

    overflow_d  = ovf_set   | (overflow_q  & ~clr_flags);
    frame_err_d = frame_set | (frame_err_q & ~clr_flags);
  end

  always_ff @(posedge i2c_core_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      scl_q        <= 1'b0;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      byte_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_q        <= scl_in;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_valid_q <= byte_valid_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge i2c_core_clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr_q] <= shift_q;
    end
  end

  assign rd_data    = empty_q ? 8'h00 : mem[rd_ptr_q];
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign fifo_count = count_q;
  assign byte_valid = byte_valid_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_i2c_rx_capture.sv
// Self-checking bench for i2c_rx_capture: a byte queue models FIFO contents and
// is compared against rd_data on every pop, with flag and latency checks per byte.
module tb_i2c_rx_capture;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          rst;
  logic          scl_in;
  logic          sda_in;
  logic          fifo_rx_enable;
  logic          rd_en;
  logic          clr_flags;
  logic [7:0]    rd_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic [AW:0]   fifo_count;
  logic          byte_valid;
  logic          overflow;
  logic          frame_err;

  int            vectors;
  int            miscompares;
  logic [7:0]    exp_q[$];
  logic          exp_ovf;
  logic          exp_ferr;

  i2c_rx_capture #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .i2c_core_clk  (clk),
    .rst           (rst),
    .scl_in        (scl_in),
    .sda_in        (sda_in),
    .fifo_rx_enable(fifo_rx_enable),
    .rd_en         (rd_en),
    .clr_flags     (clr_flags),
    .rd_data       (rd_data),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_count    (fifo_count),
    .byte_valid    (byte_valid),
    .overflow      (overflow),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic open_window();
    @(negedge clk); fifo_rx_enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic close_window();
    @(negedge clk); fifo_rx_enable = 1'b0;
    @(negedge clk);
  endtask

  // Clocks the top n bits of d, MSB first, with no push expected.
  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk); sda_in = d[i]; scl_in = 1'b0;
      @(negedge clk); scl_in = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit pop_in_push);
    logic [7:0] popped;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); sda_in = d[i]; scl_in = 1'b0;
      @(negedge clk); scl_in = 1'b1;
      if (i == 0) begin
        vectors++;
        if (byte_valid !== 1'b0) begin
          miscompares++; $display("FAIL bv_early byte=%h got=%b want=0", d, byte_valid);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (byte_valid !== 1'b1) begin
      miscompares++; $display("FAIL bv_latency byte=%h got=%b want=1", d, byte_valid);
    end
    if (pop_in_push) begin
      vectors++;
      if (rd_data !== exp_q[0]) begin
        miscompares++; $display("FAIL push_pop_head got=%h want=%h", rd_data, exp_q[0]);
      end
      popped = exp_q.pop_front();
      rd_en = 1'b1;
    end
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovf = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    $display("push byte=%h pop=%0d count=%0d exp_count=%0d ovf=%b", d, pop_in_push,
             fifo_count, exp_q.size(), overflow);
    vectors++;
    if (byte_valid !== 1'b0) begin
      miscompares++; $display("FAIL bv_pulse byte=%h got=%b want=0", d, byte_valid);
    end
    vectors++;
    if (fifo_count !== (AW+1)'(exp_q.size())) begin
      miscompares++; $display("FAIL count byte=%h got=%0d want=%0d", d, fifo_count, exp_q.size());
    end
    vectors++;
    if (fifo_full !== (exp_q.size() == DEPTH) || fifo_empty !== (exp_q.size() == 0)) begin
      miscompares++;
      $display("FAIL full_empty byte=%h got=%b%b want=%b%b", d, fifo_full, fifo_empty,
               exp_q.size() == DEPTH, exp_q.size() == 0);
    end
    vectors++;
    if (overflow !== exp_ovf) begin
      miscompares++; $display("FAIL overflow byte=%h got=%b want=%b", d, overflow, exp_ovf);
    end
  endtask

  task automatic pop_check();
    logic [7:0] want;
    @(negedge clk);
    want = exp_q.pop_front();
    vectors++;
    if (fifo_empty !== 1'b0 || rd_data !== want) begin
      miscompares++; $display("FAIL pop_data got=%h empty=%b want=%h", rd_data, fifo_empty, want);
    end
    rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    $display("pop rd_data=%h want=%h count=%0d", want, want, fifo_count);
    vectors++;
    if (fifo_count !== (AW+1)'(exp_q.size())) begin
      miscompares++; $display("FAIL pop_count got=%0d want=%0d", fifo_count, exp_q.size());
    end
  endtask

  task automatic clear_flags();
    @(negedge clk); clr_flags = 1'b1;
    @(negedge clk); clr_flags = 1'b0;
    exp_ovf = 1'b0; exp_ferr = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++; $display("FAIL clr_flags got ovf=%b ferr=%b want 0 0", overflow, frame_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_in = 1'b0; sda_in = 1'b0; fifo_rx_enable = 1'b0;
    rd_en = 1'b0; clr_flags = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_count !== '0) begin
      miscompares++;
      $display("FAIL reset_fifo got empty=%b full=%b count=%0d want 1 0 0", fifo_empty, fifo_full, fifo_count);
    end
    vectors++;
    if (byte_valid !== 1'b0 || overflow !== 1'b0 || frame_err !== 1'b0 || rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_out got bv=%b ovf=%b ferr=%b rd=%h want 0 0 0 00",
               byte_valid, overflow, frame_err, rd_data);
    end
    $display("reset done count=%0d", fifo_count);
  endtask

  task automatic test_single_byte();
    open_window();
    send_byte(8'hB4, 1'b0);
    close_window();
    pop_check();
  endtask

  task automatic test_back_to_back();
    open_window();
    send_byte(8'h3C, 1'b0);
    send_byte(8'hFF, 1'b0);
    close_window();
    pop_check();
    pop_check();
    vectors++;
    if (fifo_empty !== 1'b1) begin
      miscompares++; $display("FAIL b2b_empty got=%b want=1", fifo_empty);
    end
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    @(negedge clk);
    $display("pop on empty count=%0d", fifo_count);
    vectors++;
    if (fifo_count !== '0 || fifo_empty !== 1'b1) begin
      miscompares++; $display("FAIL empty_pop got count=%0d empty=%b want 0 1", fifo_count, fifo_empty);
    end
  endtask

  task automatic test_overflow();
    open_window();
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0);
    send_byte(8'hAA, 1'b0);
    close_window();
    for (int i = 0; i < DEPTH; i++) pop_check();
    clear_flags();
  endtask

  task automatic test_full_pop();
    open_window();
    for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b0);
    send_byte(8'h55, 1'b1);
    close_window();
    for (int i = 0; i < DEPTH; i++) pop_check();
  endtask

  task automatic test_frame_err();
    open_window();
    send_bits(8'hF8, 5);
    close_window();
    exp_ferr = 1'b1;
    vectors++;
    if (frame_err !== exp_ferr || fifo_count !== '0) begin
      miscompares++; $display("FAIL frame_err got=%b count=%0d want=1 0", frame_err, fifo_count);
    end
    clear_flags();
    open_window();
    send_byte(8'h81, 1'b0);
    close_window();
    pop_check();
  endtask

  task automatic test_reset_mid_byte();
    open_window();
    send_bits(8'hE0, 3);
    close_window();
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_ferr got=%b want=1", frame_err);
    end
    open_window();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    send_bits(8'h5A, 4);
    @(negedge clk); scl_in = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_q.delete(); exp_ovf = 1'b0; exp_ferr = 1'b0;
    $display("reset mid-byte count=%0d", fifo_count);
    vectors++;
    if (fifo_count !== '0 || fifo_empty !== 1'b1 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got count=%0d empty=%b ferr=%b ovf=%b want 0 1 0 0",
               fifo_count, fifo_empty, frame_err, overflow);
    end
    @(negedge clk);
    send_byte(8'hC3, 1'b0);
    close_window();
    pop_check();
  endtask

  initial begin
    vectors = 0; miscompares = 0; exp_ovf = 1'b0; exp_ferr = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_frame_err();
    test_reset_mid_byte();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_rx_capture.md
Name: i2c_rx_capture

Overview:
Receive-side byte capture stage directly downstream of the I2C master controller. It samples SDA on rising SCL edges while the controller's fifo_rx_enable window is high and assembles bits MSB-first into bytes. Each completed byte is pushed into an internal first-word-fall-through FIFO, which the APB register side drains.

Parameters:
FIFO_DEPTH, 8, number of byte entries; power of two, minimum 2.
ADDR_W, 3, log2(FIFO_DEPTH); pointer width.

Ports:
i2c_core_clk  input  1  single block clock, same clock that drives the controller.
rst  input  1  synchronous, active-high reset.
scl_in  input  1  SCL as driven by the controller (scl_out).
sda_in  input  1  SDA line value returned from the bus.
fifo_rx_enable  input  1  read-data window from the controller; high during READ_DATA.
rd_en  input  1  pop request from the APB side.
clr_flags  input  1  one-cycle pulse; clears overflow and frame_err.
rd_data  output  8  head FIFO entry; valid only when fifo_empty=0.
fifo_empty  output  1  FIFO holds 0 entries.
fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
fifo_count  output  ADDR_W+1  number of stored entries, 0..FIFO_DEPTH.
byte_valid  output  1  one-cycle pulse in the cycle a byte is written into the FIFO.
overflow  output  1  sticky; a byte was completed while FIFO full and no pop occurred.
frame_err  output  1  sticky; window closed with a partial byte.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over all other activity:
  - clears pointers, count, shift register, bit counter, scl_q, flags and byte_valid;
  - sets fifo_empty=1, fifo_full=0, fifo_count=0, state=IDLE;
  - rd_data=8'h00.
  - Reset mid-byte discards the partial byte and all stored entries.
- Edge detect: scl_q registers scl_in every cycle. rise = scl_in & ~scl_q. sda_in is sampled in the same cycle rise=1.
- State machine: IDLE, SHIFT, PUSH.
  - IDLE: stays until fifo_rx_enable=1, then bit_cnt=0 and go to SHIFT. A rise coinciding with the enable rising edge is captured as bit 7.
  - SHIFT, on rise: shift = {shift[6:0], sda_in}; bit_cnt+1.
    - When the 8th bit is captured (bit_cnt was 7), go to PUSH.
    - If fifo_rx_enable=0 and bit_cnt is 1..7: discard, frame_err<=1, go to IDLE.
    - If fifo_rx_enable=0 and bit_cnt=0: go to IDLE, no error. This is the normal case; the ACK clock falls outside the window.
  - PUSH, one cycle:
    - Write shift into the FIFO, pulse byte_valid=1 and reset bit_cnt=0.
    - Then go to SHIFT if fifo_rx_enable=1, otherwise IDLE.
    - A rise during PUSH is captured as bit 7 of the next byte.
  - Byte latency: byte_valid is asserted exactly 1 cycle after the cycle in which the 8th rise is sampled.
- FIFO (first-word fall-through):
  - rd_data = mem[rd_ptr] whenever fifo_empty=0.
  - A pop (rd_en=1 and not empty) advances rd_ptr. The next entry appears the following cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Boundary cases:
  - rd_en while empty: ignored; no pointer or count change.
  - Push and pop in the same cycle, not empty: both happen; count unchanged.
  - Push and pop in the same cycle, empty: push only; count becomes 1.
  - Push while full with no pop: byte dropped, overflow<=1, FIFO contents untouched, byte_valid still pulses.
  - Push while full with a pop in the same cycle: accepted; count stays FIFO_DEPTH; no overflow.
- Flags:
  - clr_flags clears overflow and frame_err.
  - If a set event occurs in the same cycle as clr_flags, the set wins.
- fifo_full, fifo_empty and fifo_count are registered and consistent with each other in every cycle.

Test Plan:
- Single byte: window high, SDA bits 1,0,1,1,0,1,0,0 on 8 rises → byte_valid pulses 1 cycle after the 8th rise; rd_data=8'hB4; fifo_count=1; fifo_empty=0.
- Two back-to-back bytes, 8'h3C then 8'hFF, window held, then pop twice → rd_data 8'h3C, then 8'hFF; fifo_empty=1 after the second pop; further rd_en leaves count=0.
- Fill 8 bytes (8'h00..8'h07) without popping, then a 9th byte 8'hAA → fifo_full=1, overflow=1, count=8; popping 8 times returns 8'h00..8'h07.
- Full FIFO with rd_en high in the cycle the 9th byte 8'h55 pushes → no overflow; count stays 8; the last entry read is 8'h55.
- Window drops after 5 rises → frame_err=1, nothing pushed; clr_flags then clears it; a following full byte 8'h81 is captured correctly.
- rst pulsed after 4 bits with 3 entries stored → next cycle count=0, fifo_empty=1, flags=0; a subsequent byte 8'hC3 is captured from bit 7.
